// File: rtl/pll_lock_supervisor_if.sv
// pll_lock_supervisor_if: PLL control/status bundle between the supervisor (master)
// and the PLL wrapper / reset distribution side (slave).
interface pll_lock_supervisor_if #(
   parameter int unsigned NUM_CH = 2,
   parameter int unsigned CNT_W  = 8
);
   logic              pll_locked;
   logic              lost_clr;
   logic              pll_resetb;
   logic              sys_resetb;
   logic [NUM_CH-1:0] ce;
   logic              lock_lost;
   logic [CNT_W-1:0]  loss_count;
   logic [2:0]        state;

   modport master (
      input  pll_locked, lost_clr,
      output pll_resetb, sys_resetb, ce, lock_lost, loss_count, state
   );

   modport slave (
      output pll_locked, lost_clr,
      input  pll_resetb, sys_resetb, ce, lock_lost, loss_count, state
   );
endinterface

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: sequences PLL RESETB, qualifies LOCK, releases the system reset
// after stable lock, recovers from lock loss and generates divided tick strobes.
// Optional feature macro: PLL_LOSS_COUNT_EN (saturating lock-loss counter).
module pll_lock_supervisor #(
   parameter int unsigned             NUM_CH       = 2,
   parameter int unsigned             DIV_W        = 25,
   parameter logic [NUM_CH*DIV_W-1:0] CH_DIV       = {25'd24000000, 25'd24000},
   parameter int unsigned             PLL_RST_CYC  = 16,
   parameter int unsigned             LOCK_STABLE  = 1024,
   parameter int unsigned             LOCK_TIMEOUT = 65536,
   parameter int unsigned             CNT_W        = 8
) (
   input logic                   clock_in,
   input logic                   resetb,
   pll_lock_supervisor_if.master bus
);
   localparam logic [2:0] ST_PLL_RST   = 3'd0;
   localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
   localparam logic [2:0] ST_STABLE    = 3'd2;
   localparam logic [2:0] ST_RUN       = 3'd3;
   localparam logic [2:0] ST_FAULT     = 3'd4;

   localparam int unsigned MAX_A   = (PLL_RST_CYC > LOCK_STABLE) ? PLL_RST_CYC : LOCK_STABLE;
   localparam int unsigned TMR_MAX = (MAX_A > LOCK_TIMEOUT) ? MAX_A : LOCK_TIMEOUT;
   localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

   logic [2:0]                    state_q, state_d;
   logic [TMR_W-1:0]              tmr_q, tmr_d;
   logic [1:0]                    sync_q, sync_d;
   logic                          pll_resetb_q, pll_resetb_d;
   logic                          sys_resetb_q, sys_resetb_d;
   logic                          lock_lost_q, lock_lost_d;
   logic [NUM_CH-1:0]             ce_q, ce_d;
   logic [NUM_CH-1:0][DIV_W-1:0]  dcnt_q, dcnt_d;
   logic                          locked_s;

   function automatic logic [DIV_W-1:0] ch_div(input int unsigned i);
      return CH_DIV[i*DIV_W +: DIV_W];
   endfunction

   assign locked_s = sync_q[1];

   // Lock synchroniser, FSM next state and the shared phase timer
   always_comb begin
      sync_d  = {sync_q[0], bus.pll_locked};
      state_d = state_q;
      tmr_d   = tmr_q + TMR_W'(1);
      case (state_q)
         ST_PLL_RST: begin
            if (tmr_q == TMR_W'(PLL_RST_CYC - 1)) state_d = ST_WAIT_LOCK;
         end
         ST_WAIT_LOCK: begin
            if (locked_s)                              state_d = ST_STABLE;
            else if (tmr_q == TMR_W'(LOCK_TIMEOUT - 1)) state_d = ST_PLL_RST;
         end
         ST_STABLE: begin
            if (!locked_s)                             state_d = ST_WAIT_LOCK;
            else if (tmr_q == TMR_W'(LOCK_STABLE - 1)) state_d = ST_RUN;
         end
         ST_RUN: begin
            tmr_d = '0;
            if (!locked_s) state_d = ST_FAULT;
         end
         ST_FAULT: begin
            tmr_d   = '0;
            state_d = ST_PLL_RST;
         end
         default: begin
            state_d = ST_PLL_RST;
         end
      endcase
      if (state_d != state_q) tmr_d = '0;
   end

   // Registered outputs decoded from the next state; sticky loss flag where set beats clear
   always_comb begin
      pll_resetb_d = (state_d != ST_PLL_RST);
      sys_resetb_d = (state_d == ST_RUN);
      lock_lost_d  = (state_d == ST_FAULT) || (state_q == ST_FAULT) ||
                     (lock_lost_q && !bus.lost_clr);
   end

   // Tick dividers: count RUN cycles 1..DIV and strobe on DIV; idle outside RUN
   always_comb begin
      dcnt_d = '0;
      ce_d   = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (state_d == ST_RUN) begin
            if (ch_div(i) <= DIV_W'(1)) begin
               ce_d[i] = 1'b1;
            end else begin
               if ((state_q != ST_RUN) || (dcnt_q[i] == ch_div(i))) dcnt_d[i] = DIV_W'(1);
               else                                                 dcnt_d[i] = dcnt_q[i] + DIV_W'(1);
               ce_d[i] = (dcnt_d[i] == ch_div(i));
            end
         end
      end
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clock_in) begin
      if (!resetb) begin
         state_q      <= ST_PLL_RST;
         tmr_q        <= '0;
         sync_q       <= '0;
         pll_resetb_q <= 1'b0;
         sys_resetb_q <= 1'b0;
         lock_lost_q  <= 1'b0;
         ce_q         <= '0;
         dcnt_q       <= '0;
      end else begin
         state_q      <= state_d;
         tmr_q        <= tmr_d;
         sync_q       <= sync_d;
         pll_resetb_q <= pll_resetb_d;
         sys_resetb_q <= sys_resetb_d;
         lock_lost_q  <= lock_lost_d;
         ce_q         <= ce_d;
         dcnt_q       <= dcnt_d;
      end
   end

`ifdef PLL_LOSS_COUNT_EN
   logic [CNT_W-1:0] loss_count_q, loss_count_d;

   // Saturating count of lock losses, bumped on FAULT entry
   always_comb begin
      loss_count_d = loss_count_q;
      if ((state_d == ST_FAULT) && (loss_count_q != '1)) loss_count_d = loss_count_q + CNT_W'(1);
   end

   // Loss counter register
   always_ff @(posedge clock_in) begin
      if (!resetb) loss_count_q <= '0;
      else         loss_count_q <= loss_count_d;
   end

   assign bus.loss_count = loss_count_q;
`else
   assign bus.loss_count = CNT_W'(0);
`endif

   assign bus.state      = state_q;
   assign bus.pll_resetb = pll_resetb_q;
   assign bus.sys_resetb = sys_resetb_q;
   assign bus.lock_lost  = lock_lost_q;
   assign bus.ce         = ce_q;
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor: directed stimulus, cycle-level reference model and
// hand-computed expectations for pll_lock_supervisor (small bench parameters).
module tb_pll_lock_supervisor;
   localparam int unsigned NUM_CH       = 2;
   localparam int unsigned DIV_W        = 25;
   localparam int unsigned PLL_RST_CYC  = 4;
   localparam int unsigned LOCK_STABLE  = 8;
   localparam int unsigned LOCK_TIMEOUT = 64;
   localparam int unsigned CNT_W        = 8;
   localparam logic [NUM_CH*DIV_W-1:0] CH_DIV = {25'd5, 25'd3};
   localparam int DIV0    = 3;
   localparam int DIV1    = 5;
   localparam int CNT_SAT = 255;
`ifdef PLL_LOSS_COUNT_EN
   localparam int EXP_ONE = 1;
   localparam int EXP_SAT = 255;
`else
   localparam int EXP_ONE = 0;
   localparam int EXP_SAT = 0;
`endif
   localparam int RN = 160;

   logic clk = 1'b0;
   logic resetb;
   bit   chk_en = 1'b0;
   int   n_checks = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   pll_lock_supervisor_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

   pll_lock_supervisor #(
      .NUM_CH(NUM_CH), .DIV_W(DIV_W), .CH_DIV(CH_DIV), .PLL_RST_CYC(PLL_RST_CYC),
      .LOCK_STABLE(LOCK_STABLE), .LOCK_TIMEOUT(LOCK_TIMEOUT), .CNT_W(CNT_W)
   ) dut (
      .clock_in(clk),
      .resetb(resetb),
      .bus(bus.master)
   );

   // Reference model: phase = spec state number, m_t = cycles completed in phase,
   // m_run = 1-based index of the current RUN cycle.
   int m_phase = 0, m_t = 0, m_run = 0, m_cnt = 0;
   bit m_lost = 0, m_s1 = 0, m_s2 = 0;

   always @(posedge clk) begin : model
      int nxt;
      bit ls;
      if (!resetb) begin
         m_phase = 0; m_t = 0; m_run = 0; m_cnt = 0;
         m_lost = 0; m_s1 = 0; m_s2 = 0;
      end else begin
         ls   = m_s2;
         m_s2 = m_s1;
         m_s1 = bus.pll_locked;
         nxt  = m_phase;
         m_t  = m_t + 1;
         case (m_phase)
            0: if (m_t == PLL_RST_CYC) nxt = 1;
            1: if (ls) nxt = 2; else if (m_t == LOCK_TIMEOUT) nxt = 0;
            2: if (!ls) nxt = 1; else if (m_t == LOCK_STABLE) nxt = 3;
            3: if (!ls) nxt = 4;
            default: nxt = 0;
         endcase
         if (nxt == 4 || m_phase == 4) m_lost = 1;
         else if (bus.lost_clr)         m_lost = 0;
         if (nxt == 4 && m_cnt < CNT_SAT) m_cnt = m_cnt + 1;
         if (nxt != m_phase) m_t = 0;
         m_run   = (nxt == 3) ? m_run + 1 : 0;
         m_phase = nxt;
      end
   end

   function automatic logic [15:0] model_vec();
      logic [1:0] ce;
      logic [7:0] lc;
      ce[0] = (m_phase == 3) && (DIV0 <= 1 || (m_run % DIV0) == 0);
      ce[1] = (m_phase == 3) && (DIV1 <= 1 || (m_run % DIV1) == 0);
`ifdef PLL_LOSS_COUNT_EN
      lc = 8'(m_cnt);
`else
      lc = 8'd0;
`endif
      return {3'(m_phase), m_phase != 0, m_phase == 3, ce, m_lost, lc};
   endfunction

   // Per-cycle comparison of every output against the model
   always @(negedge clk) begin
      logic [15:0] act, exp;
      if (chk_en) begin
         act = {bus.state, bus.pll_resetb, bus.sys_resetb, bus.ce, bus.lock_lost, bus.loss_count};
         exp = model_vec();
         n_checks++;
         if (act === exp) n_pass++;
         else $display("FAIL cycle_compare t=%0t dut=%h model=%h", $time, act, exp);
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   int r_state[0:RN-1], r_pr[0:RN-1], r_sr[0:RN-1];
   int r_ce0[0:RN-1], r_ce1[0:RN-1], r_lost[0:RN-1], r_cnt[0:RN-1];

   // Log outputs at each negedge and drive the inputs for the following cycle
   task automatic record(input int n, input bit base, input int lo_from, input int lo_to,
                         input int clr_at);
      for (int c = 0; c < n; c++) begin
         r_state[c] = int'(bus.state);
         r_pr[c]    = int'(bus.pll_resetb);
         r_sr[c]    = int'(bus.sys_resetb);
         r_ce0[c]   = int'(bus.ce[0]);
         r_ce1[c]   = int'(bus.ce[1]);
         r_lost[c]  = int'(bus.lock_lost);
         r_cnt[c]   = int'(bus.loss_count);
         bus.pll_locked = (c >= lo_from && c < lo_to) ? 1'b0 : base;
         bus.lost_clr   = (c == clr_at);
         @(negedge clk);
      end
      bus.lost_clr = 1'b0;
   endtask

   task automatic do_reset(input bit lk);
      resetb = 1'b0;
      bus.pll_locked = lk;
      bus.lost_clr = 1'b0;
      repeat (3) @(negedge clk);
      resetb = 1'b1;
   endtask

   function automatic int count_val(input int a[0:RN-1], input int v, input int lo, input int hi);
      int k = 0;
      for (int i = lo; i <= hi; i++) if (a[i] == v) k++;
      return k;
   endfunction

   function automatic int first_val(input int a[0:RN-1], input int v, input int lo, input int hi);
      for (int i = lo; i <= hi; i++) if (a[i] == v) return i;
      return -1;
   endfunction

   initial begin
      resetb = 1'b0;
      bus.pll_locked = 1'b0;
      bus.lost_clr = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk_en = 1'b1;
      check("rst_state", int'(bus.state), 0);
      check("rst_pll_resetb", int'(bus.pll_resetb), 0);
      check("rst_sys_resetb", int'(bus.sys_resetb), 0);
      check("rst_ce", int'(bus.ce), 0);

      // Constant lock: 4 PLL reset cycles, RUN from cycle 13, ticks every 3 / 5
      do_reset(1'b1);
      record(25, 1'b1, -1, -1, -1);
      check("t1_prst_low_cycles", count_val(r_pr, 0, 0, 19), 4);
      check("t1_sys_rise", first_val(r_sr, 1, 0, 24), 13);
      check("t1_ce0_first", first_val(r_ce0, 1, 0, 24), 15);
      check("t1_ce1_first", first_val(r_ce1, 1, 0, 24), 17);
      check("t1_ce0_count", count_val(r_ce0, 1, 13, 24), 4);
      check("t1_ce1_count", count_val(r_ce1, 1, 13, 24), 2);
      check("t1_state_run", r_state[24], 3);

      // No lock: retry every 68 cycles, never released
      do_reset(1'b0);
      record(140, 1'b0, -1, -1, -1);
      check("t2_prst_low_cycles", count_val(r_pr, 0, 0, 139), 12);
      check("t2_prst_c67", r_pr[67], 1);
      check("t2_prst_c68", r_pr[68], 0);
      check("t2_prst_c72", r_pr[72], 1);
      check("t2_sys_high", count_val(r_sr, 1, 0, 139), 0);
      check("t2_ce_high", count_val(r_ce0, 1, 0, 139) + count_val(r_ce1, 1, 0, 139), 0);

      // One-cycle lock glitch seen at STABLE count 5
      do_reset(1'b1);
      record(30, 1'b1, 8, 9, -1);
      check("t3_state_c10", r_state[10], 2);
      check("t3_state_c11", r_state[11], 1);
      check("t3_state_c12", r_state[12], 2);
      check("t3_sys_rise", first_val(r_sr, 1, 0, 29), 20);

      // Lock loss in RUN, relock, then clear the sticky flag
      do_reset(1'b1);
      record(50, 1'b1, 25, 29, -1);
      check("t4_sys_c27", r_sr[27], 1);
      check("t4_ce0_c27", r_ce0[27], 1);
      check("t4_ce1_c27", r_ce1[27], 1);
      check("t4_state_c28", r_state[28], 4);
      check("t4_sys_c28", r_sr[28], 0);
      check("t4_ce_c28", r_ce0[28] + r_ce1[28], 0);
      check("t4_lost_c27", r_lost[27], 0);
      check("t4_lost_c28", r_lost[28], 1);
      check("t4_cnt_c28", r_cnt[28], EXP_ONE);
      check("t4_state_c29", r_state[29], 0);
      check("t4_relock_rise", first_val(r_sr, 1, 28, 49), 42);
      record(3, 1'b1, -1, -1, 0);
      check("t4_lost_before_clr", r_lost[0], 1);
      check("t4_lost_after_clr", r_lost[1], 0);

      // Clear pulsed during the FAULT cycle: set must win
      do_reset(1'b1);
      record(35, 1'b1, 25, 29, 28);
      check("t5_lost_fault", r_lost[28], 1);
      check("t5_lost_after", r_lost[29], 1);
      check("t5_lost_later", r_lost[30], 1);

      // 300 losses: counter saturates (or stays 0 without the counter)
      do_reset(1'b1);
      record(20, 1'b1, -1, -1, -1);
      for (int k = 0; k < 300; k++) record(26, 1'b1, 0, 4, -1);
      check("t6_loss_count", int'(bus.loss_count), EXP_SAT);
      check("t6_lock_lost", int'(bus.lock_lost), 1);
      check("t6_sys_run", int'(bus.sys_resetb), 1);

      // Reset asserted mid-RUN
      resetb = 1'b0;
      @(negedge clk);
      check("t7_state", int'(bus.state), 0);
      check("t7_pll_resetb", int'(bus.pll_resetb), 0);
      check("t7_sys_resetb", int'(bus.sys_resetb), 0);
      check("t7_ce", int'(bus.ce), 0);
      check("t7_lock_lost", int'(bus.lock_lost), 0);
      check("t7_loss_count", int'(bus.loss_count), 0);
      resetb = 1'b1;
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
